// File: rtl/mode_controller_pkg.sv
// Shared encodings and sizing helpers for the front-panel mode controller.
package mode_controller_pkg;

  localparam int MEGA = 1_000_000;

  typedef enum logic [1:0] {
    MODE_CLOCK = 2'd0,
    MODE_TIMER = 2'd1,
    MODE_ALARM = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    SELECT_NONE = 2'd0,
    SELECT_SEC  = 2'd1,
    SELECT_MIN  = 2'd2,
    SELECT_HOUR = 2'd3
  } select_t;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_RING   = 1'b1
  } state_t;

  localparam int NUM_BTN = 5;
  localparam int BTN_C   = 0;
  localparam int BTN_U   = 1;
  localparam int BTN_L   = 2;
  localparam int BTN_R   = 3;
  localparam int BTN_D   = 4;

  // Bits needed to hold 0..max_val (never less than 1).
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic select_t next_select(input select_t s);
    case (s)
      SELECT_NONE: return SELECT_SEC;
      SELECT_SEC:  return SELECT_MIN;
      SELECT_MIN:  return SELECT_HOUR;
      default:     return SELECT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mode_controller_button_debounce.sv
// One push-button: 2-flop synchroniser, stable-level debounce counter and
// a single-cycle pulse on the accepted rising edge.
module button_debounce
  import mode_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = MEGA
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int            CW      = cnt_w(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          mismatch;

  assign mismatch = sync[1] ^ level;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      if (!mismatch) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        // DEBOUNCE_CYCLES-th consecutive differing sample: accept new level
        cnt   <= '0;
        level <= sync[1];
        press <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mode_controller.sv
// Front-panel sequencer: debounced buttons, mode/select FSM, alarm/timer
// ring arbitration with acknowledge, auto-timeout and square-wave tone.
module mode_controller
  import mode_controller_pkg::*;
#(
  parameter int CLK_FREQ        = 100 * MEGA,
  parameter int DEBOUNCE_CYCLES = MEGA,
  parameter int TONE_HZ         = 1500,
  parameter int RING_TIMEOUT_S  = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_c,
  input  logic       btn_u,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_d,
  input  logic       alarm_out,
  input  logic       timer_out,
  output logic [1:0] mode,
  output logic [1:0] select,
  output logic       increment,
  output logic       alarm_enable,
  output logic       timer_enable,
  output logic       ringing,
  output logic       ring_src,
  output logic       aud_pwm
);

  localparam int HALF    = CLK_FREQ / (2 * TONE_HZ);
  localparam int PRE_W   = cnt_w(CLK_FREQ - 1);
  localparam int SEC_W   = cnt_w(RING_TIMEOUT_S - 1);
  localparam int TONE_W  = cnt_w(HALF - 1);
  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(CLK_FREQ - 1);
  localparam logic [SEC_W-1:0]  SEC_MAX  = SEC_W'(RING_TIMEOUT_S - 1);
  localparam logic [TONE_W-1:0] TONE_MAX = TONE_W'(HALF - 1);

  logic [NUM_BTN-1:0] btn_raw, btn_lvl, btn_press;

  assign btn_raw = {btn_d, btn_r, btn_l, btn_u, btn_c};

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_raw[gi]),
      .level (btn_lvl[gi]),
      .press (btn_press[gi])
    );
  end

  logic unused_btn;
  assign unused_btn = ^{btn_lvl[BTN_C], btn_lvl[BTN_L], btn_lvl[BTN_R],
                        btn_lvl[BTN_D], btn_press[BTN_U]};

  state_t  state, state_n;
  mode_t   mode_r, mode_n, saved_mode, saved_mode_n;
  select_t sel_r, sel_n, saved_sel, saved_sel_n;
  logic    alarm_en_n, timer_en_n, ring_src_n;
  logic    mask_a, mask_a_n, mask_t, mask_t_n;
  logic    elig_a, elig_t, timeout, ack, ring_run;

  logic [PRE_W-1:0]  pre_cnt;
  logic [SEC_W-1:0]  sec_cnt;
  logic [TONE_W-1:0] tone_cnt;

  assign elig_a   = alarm_out & ~mask_a;
  assign elig_t   = timer_out & ~mask_t;
  assign ringing  = (state == ST_RING);
  assign timeout  = (pre_cnt == PRE_MAX) && (sec_cnt == SEC_MAX);
  assign ack      = ringing & (btn_press[BTN_C] | timeout);
  assign ring_run = ringing & ~ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_NORMAL;
      mode_r       <= MODE_CLOCK;
      sel_r        <= SELECT_NONE;
      saved_mode   <= MODE_CLOCK;
      saved_sel    <= SELECT_NONE;
      alarm_enable <= 1'b0;
      timer_enable <= 1'b0;
      ring_src     <= 1'b0;
      mask_a       <= 1'b0;
      mask_t       <= 1'b0;
    end else begin
      state        <= state_n;
      mode_r       <= mode_n;
      sel_r        <= sel_n;
      saved_mode   <= saved_mode_n;
      saved_sel    <= saved_sel_n;
      alarm_enable <= alarm_en_n;
      timer_enable <= timer_en_n;
      ring_src     <= ring_src_n;
      mask_a       <= mask_a_n;
      mask_t       <= mask_t_n;
    end
  end

  always_comb begin
    state_n      = state;
    mode_n       = mode_r;
    sel_n        = sel_r;
    saved_mode_n = saved_mode;
    saved_sel_n  = saved_sel;
    alarm_en_n   = alarm_enable;
    timer_en_n   = timer_enable;
    ring_src_n   = ring_src;
    // Masks hold only while their event level persists
    mask_a_n     = mask_a & alarm_out;
    mask_t_n     = mask_t & timer_out;
    case (state)
      ST_NORMAL: begin
        if (elig_a || elig_t) begin
          state_n      = ST_RING;
          saved_mode_n = mode_r;
          saved_sel_n  = sel_r;
          ring_src_n   = ~elig_a;
          mode_n       = elig_a ? MODE_ALARM : MODE_TIMER;
          sel_n        = SELECT_NONE;
        end else begin
          if (btn_press[BTN_L]) alarm_en_n = ~alarm_enable;
          if (btn_press[BTN_C] && mode_r == MODE_TIMER) timer_en_n = ~timer_enable;
          if (btn_press[BTN_R]) begin
            case (mode_r)
              MODE_CLOCK: begin
                mode_n = MODE_TIMER;
                sel_n  = SELECT_SEC;
              end
              MODE_TIMER: begin
                mode_n     = MODE_ALARM;
                sel_n      = SELECT_SEC;
                timer_en_n = 1'b0;
              end
              default: begin
                mode_n = MODE_CLOCK;
                sel_n  = SELECT_NONE;
              end
            endcase
          end else if (btn_press[BTN_D]) begin
            sel_n = next_select(sel_r);
          end
        end
      end
      ST_RING: begin
        if (ack) begin
          state_n = ST_NORMAL;
          mode_n  = saved_mode;
          sel_n   = saved_sel;
          if (ring_src) begin
            mask_t_n   = 1'b1;
            timer_en_n = 1'b0;
          end else begin
            mask_a_n = 1'b1;
          end
        end
      end
      default: state_n = ST_NORMAL;
    endcase
  end

  // Prescaler and tone run only while the ring continues past this cycle,
  // so both read 0 on the first cycle after acknowledge.
  always_ff @(posedge clk) begin
    if (reset || !ring_run) begin
      pre_cnt  <= '0;
      sec_cnt  <= '0;
      tone_cnt <= '0;
      aud_pwm  <= 1'b0;
    end else begin
      if (pre_cnt == PRE_MAX) begin
        pre_cnt <= '0;
        sec_cnt <= sec_cnt + 1'b1;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
      if (tone_cnt == TONE_MAX) begin
        tone_cnt <= '0;
        aud_pwm  <= ~aud_pwm;
      end else begin
        tone_cnt <= tone_cnt + 1'b1;
      end
    end
  end

  assign mode      = mode_r;
  assign select    = sel_r;
  assign increment = btn_lvl[BTN_U] & ~ringing;

endmodule

// File: tb/tb_mode_controller.sv
// Directed bench for mode_controller with short debounce/tone/timeout params.
module tb_mode_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_c, btn_u, btn_l, btn_r, btn_d;
  logic       alarm_out, timer_out;
  logic [1:0] mode, select;
  logic       increment, alarm_enable, timer_enable, ringing, ring_src, aud_pwm;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mode_controller #(
    .CLK_FREQ(1000), .DEBOUNCE_CYCLES(4), .TONE_HZ(100), .RING_TIMEOUT_S(2)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_c(btn_c), .btn_u(btn_u), .btn_l(btn_l), .btn_r(btn_r), .btn_d(btn_d),
    .alarm_out(alarm_out), .timer_out(timer_out),
    .mode(mode), .select(select), .increment(increment),
    .alarm_enable(alarm_enable), .timer_enable(timer_enable),
    .ringing(ringing), .ring_src(ring_src), .aud_pwm(aud_pwm)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Full press: held 10 cycles (> 7 latency), released 10 cycles.
  task automatic press_btn(input int which);
    case (which)
      0: btn_c = 1'b1;
      2: btn_l = 1'b1;
      3: btn_r = 1'b1;
      default: btn_d = 1'b1;
    endcase
    step(10);
    {btn_c, btn_l, btn_r, btn_d} = '0;
    step(10);
  endtask

  initial begin
    reset = 1'b1;
    {btn_c, btn_u, btn_l, btn_r, btn_d} = '0;
    {alarm_out, timer_out} = '0;
    step(2);
    reset = 1'b0;
    check("rst_mode", mode, 0);
    check("rst_select", select, 0);
    check("rst_alarm_en", alarm_enable, 0);
    check("rst_timer_en", timer_enable, 0);
    check("rst_ringing", ringing, 0);
    check("rst_ring_src", ring_src, 0);
    check("rst_aud", aud_pwm, 0);
    check("rst_incr", increment, 0);

    // 3-cycle glitch on btn_r is rejected
    btn_r = 1'b1; step(3); btn_r = 1'b0; step(10);
    check("glitch_mode", mode, 0);

    // Clean press: mode change lands exactly 7 cycles after raw edge
    btn_r = 1'b1; step(6);
    check("lat6_mode", mode, 0);
    step(1);
    check("lat7_mode", mode, 1);
    check("lat7_select", select, 1);
    step(3); btn_r = 1'b0; step(10);
    check("single_press", mode, 1);

    // Timer run, then mode sequence
    press_btn(0);
    check("c_in_timer", timer_enable, 1);
    press_btn(3);
    check("r_to_alarm_mode", mode, 2);
    check("r_to_alarm_sel", select, 1);
    check("r_to_alarm_ten", timer_enable, 0);
    press_btn(3);
    check("r_to_clock_mode", mode, 0);
    check("r_to_clock_sel", select, 0);
    press_btn(4); check("d1", select, 1);
    press_btn(4); check("d2", select, 2);
    press_btn(4); check("d3", select, 3);
    press_btn(4); check("d4", select, 0);
    press_btn(0);
    check("c_ignored_clock", timer_enable, 0);
    press_btn(2);
    check("l_toggle", alarm_enable, 1);
    btn_u = 1'b1; step(8);
    check("incr_high", increment, 1);
    btn_u = 1'b0; step(10);
    check("incr_low", increment, 0);

    // Alarm ring with acknowledge
    press_btn(4); press_btn(4);
    check("pre_ring_sel", select, 2);
    alarm_out = 1'b1; step(1);
    check("ring_a_on", ringing, 1);
    check("ring_a_src", ring_src, 0);
    check("ring_a_mode", mode, 2);
    check("ring_a_sel", select, 0);
    step(4); check("aud_p5", aud_pwm, 0);
    step(1); check("aud_p6", aud_pwm, 1);
    step(4); check("aud_p10", aud_pwm, 1);
    step(1); check("aud_p11", aud_pwm, 0);
    btn_u = 1'b1; btn_r = 1'b1; step(8);
    check("ring_incr_gated", increment, 0);
    step(2); btn_u = 1'b0; btn_r = 1'b0; step(10);
    check("ring_r_ignored", mode, 2);
    check("ring_still", ringing, 1);
    btn_c = 1'b1; step(6);
    check("ack_pending", ringing, 1);
    step(1);
    check("ack_ringing", ringing, 0);
    check("ack_mode", mode, 0);
    check("ack_sel", select, 2);
    check("ack_aud", aud_pwm, 0);
    btn_c = 1'b0; step(10);
    check("no_rering", ringing, 0);
    alarm_out = 1'b0; step(2);

    // Simultaneous events from TIMER mode with timer running
    press_btn(3);
    press_btn(0);
    check("sim_pre_mode", mode, 1);
    check("sim_pre_ten", timer_enable, 1);
    alarm_out = 1'b1; timer_out = 1'b1; step(1);
    check("sim_ring", ringing, 1);
    check("sim_src_a", ring_src, 0);
    check("sim_mode_a", mode, 2);
    btn_c = 1'b1; step(7);
    check("sim_ack1_ring", ringing, 0);
    check("sim_ack1_mode", mode, 1);
    check("sim_ack1_ten", timer_enable, 1);
    step(1);
    check("sim_rering", ringing, 1);
    check("sim_src_t", ring_src, 1);
    check("sim_mode_t", mode, 1);
    check("sim_sel_t", select, 0);
    btn_c = 1'b0; step(10);
    btn_c = 1'b1; step(7);
    check("sim_ack2_ring", ringing, 0);
    check("sim_ack2_ten", timer_enable, 0);
    check("sim_ack2_mode", mode, 1);
    check("sim_ack2_sel", select, 1);
    btn_c = 1'b0; step(10);
    check("sim_quiet", ringing, 0);
    alarm_out = 1'b0; timer_out = 1'b0; step(2);

    // Auto-acknowledge after 2000 cycles
    alarm_out = 1'b1; step(1);
    check("to_ring", ringing, 1);
    step(1999);
    check("to_before", ringing, 1);
    step(1);
    check("to_after", ringing, 0);
    check("to_mode", mode, 1);
    check("to_sel", select, 1);
    alarm_out = 1'b0; step(2);

    // Reset mid-ring; event still present rings again
    timer_out = 1'b1; step(3);
    check("rr_ring", ringing, 1);
    check("rr_src", ring_src, 1);
    reset = 1'b1; step(1);
    check("rr_mode", mode, 0);
    check("rr_ringing", ringing, 0);
    check("rr_aud", aud_pwm, 0);
    check("rr_sel", select, 0);
    reset = 1'b0; step(1);
    check("rr_rering", ringing, 1);
    check("rr_rering_src", ring_src, 1);
    timer_out = 1'b0; step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
